// File: rtl/freq_sel_pkg.sv
// Shared types and default widths for the frequency-selector read scheduler.
package freq_sel_pkg;

   localparam int IDX_WIDTH  = 14;  // matches dout_mon
   localparam int SLOT_WIDTH = 14;
   localparam int DIV_WIDTH  = 16;
   localparam int FCNT_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      READ = 2'd2,
      GAP  = 2'd3
   } state_t;

endpackage

// File: rtl/freq_sel_tick_gen.sv
// Reloadable down-counter. o_zero is the read-due strobe in READ and the
// gap-done strobe in GAP; the counter parks at zero until reloaded.
module freq_sel_tick_gen #(
   parameter int W = 17
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_dec,
   output logic         o_zero
);

   localparam logic [W-1:0] C_ONE = 1;

   logic [W-1:0] r_cnt;

   // load has priority over decrement; never decrement below zero
   always_ff @(posedge i_clk) begin
      if (i_rst)                       r_cnt <= '0;
      else if (i_load)                 r_cnt <= i_load_val;
      else if (i_dec && r_cnt != '0)   r_cnt <= r_cnt - C_ONE;
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/freq_sel_scheduler.sv
// Read scheduler for the frequency-selector tone ring (dev_clk domain).
// Steps the ring, tags returned tone indices with their slot, repeats frames
// with programmable spacing and inter-frame gap, tracks underflow and frames.
// Optional: define FREQ_SEL_SCHED_OVF_CNT_EN to add o_underflow_cnt[15:0].
module freq_sel_scheduler #(
   parameter int IDX_WIDTH  = freq_sel_pkg::IDX_WIDTH,
   parameter int SLOT_WIDTH = freq_sel_pkg::SLOT_WIDTH,
   parameter int DIV_WIDTH  = freq_sel_pkg::DIV_WIDTH,
   parameter int FCNT_WIDTH = freq_sel_pkg::FCNT_WIDTH
) (
   input  logic                  i_dev_clk,
   input  logic                  i_dev_rst,
   input  logic                  i_start,
   input  logic                  i_stop,
   input  logic [SLOT_WIDTH-1:0] i_cfg_n_tones,
   input  logic [DIV_WIDTH-1:0]  i_cfg_div,
   input  logic [DIV_WIDTH-1:0]  i_cfg_gap,
   input  logic                  i_ring_empty,
   input  logic [IDX_WIDTH-1:0]  i_ring_dout,
   output logic                  o_rd_en_ring,
   output logic                  o_tone_valid,
   output logic [IDX_WIDTH-1:0]  o_tone_idx,
   output logic [SLOT_WIDTH-1:0] o_tone_slot,
   output logic                  o_frame_start,
   output logic                  o_busy,
   output logic                  o_underflow,
   output logic [FCNT_WIDTH-1:0] o_frame_cnt
`ifdef FREQ_SEL_SCHED_OVF_CNT_EN
   ,
   output logic [15:0]           o_underflow_cnt
`endif
);

   import freq_sel_pkg::*;

   // one extra bit so div+gap-1 cannot wrap
   localparam int CW = DIV_WIDTH + 1;
   localparam logic [CW-1:0]         C_ONE    = 1;
   localparam logic [SLOT_WIDTH-1:0] SLOT_ONE = 1;
   localparam logic [FCNT_WIDTH-1:0] FCNT_ONE = 1;

   state_t                r_state;
   logic [SLOT_WIDTH-1:0] r_n, r_slot;
   logic [DIV_WIDTH-1:0]  r_div, r_gap;
   logic                  r_stop_pend;
   logic                  r_underflow;
   logic [FCNT_WIDTH-1:0] r_frame_cnt;
   logic                  r_cap_pend;
   logic [SLOT_WIDTH-1:0] r_cap_slot;
   logic                  r_tone_valid;
   logic [IDX_WIDTH-1:0]  r_tone_idx;
   logic [SLOT_WIDTH-1:0] r_tone_slot;

   logic                  w_zero, w_due, w_last, w_stop, w_rd, w_accept;
   logic                  w_load, w_dec;
   logic [CW-1:0]         w_load_val;

   assign w_due    = (r_state == READ) && w_zero;
   assign w_last   = (r_slot == (r_n - SLOT_ONE));
   assign w_stop   = r_stop_pend | i_stop;
   assign w_rd     = w_due & ~i_ring_empty;
   assign w_accept = (r_state == IDLE) && i_start && !i_stop && (i_cfg_n_tones != '0);

   // Counter control. Leaving for GAP loads div+gap-1 so the next slot-0 read
   // lands exactly div+1+gap cycles after the last read of the frame.
   always_comb begin
      w_load     = 1'b0;
      w_dec      = 1'b0;
      w_load_val = '0;
      case (r_state)
         ARM:  w_load = 1'b1;
         READ: begin
            if (w_zero) begin
               w_load = 1'b1;
               if (w_last && !w_stop && r_gap != '0)
                  w_load_val = {1'b0, r_div} + {1'b0, r_gap} - C_ONE;
               else
                  w_load_val = {1'b0, r_div};
            end else begin
               w_dec = 1'b1;
            end
         end
         GAP:  w_dec = !w_zero;
         default: ;
      endcase
   end

   freq_sel_tick_gen #(.W(CW)) u_tick (
      .i_clk      (i_dev_clk),
      .i_rst      (i_dev_rst),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .i_dec      (w_dec),
      .o_zero     (w_zero)
   );

   // Main FSM: framing, slot tracking, stop handling, underflow and frame count
   always_ff @(posedge i_dev_clk) begin
      if (i_dev_rst) begin
         r_state     <= IDLE;
         r_n         <= '0;
         r_slot      <= '0;
         r_div       <= '0;
         r_gap       <= '0;
         r_stop_pend <= 1'b0;
         r_underflow <= 1'b0;
         r_frame_cnt <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               r_stop_pend <= 1'b0;
               if (w_accept) begin
                  r_underflow <= 1'b0;
                  r_state     <= ARM;
               end
            end
            ARM: begin
               r_n         <= i_cfg_n_tones;
               r_div       <= i_cfg_div;
               r_gap       <= i_cfg_gap;
               r_slot      <= '0;
               r_stop_pend <= w_stop;
               r_state     <= READ;
            end
            READ: begin
               r_stop_pend <= w_stop;
               if (w_due) begin
                  if (i_ring_empty) r_underflow <= 1'b1;
                  if (w_last) begin
                     r_slot      <= '0;
                     r_frame_cnt <= r_frame_cnt + FCNT_ONE;
                     if (w_stop) begin
                        r_stop_pend <= 1'b0;
                        r_state     <= IDLE;
                     end else if (r_gap != '0) begin
                        r_state     <= GAP;
                     end
                  end else begin
                     r_slot <= r_slot + SLOT_ONE;
                  end
               end
            end
            GAP: begin
               r_stop_pend <= w_stop;
               // a stop during the gap ends framing instead of opening a new frame
               if (w_zero) r_state <= w_stop ? IDLE : READ;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Capture: ring data arrives the cycle after the strobe, registered one later
   always_ff @(posedge i_dev_clk) begin
      if (i_dev_rst) begin
         r_cap_pend   <= 1'b0;
         r_cap_slot   <= '0;
         r_tone_valid <= 1'b0;
         r_tone_idx   <= '0;
         r_tone_slot  <= '0;
      end else begin
         r_cap_pend   <= w_rd;
         r_cap_slot   <= r_slot;
         r_tone_valid <= r_cap_pend;
         if (r_cap_pend) begin
            r_tone_idx  <= i_ring_dout;
            r_tone_slot <= r_cap_slot;
         end
      end
   end

`ifdef FREQ_SEL_SCHED_OVF_CNT_EN
   logic [15:0] r_uf_cnt;
   localparam logic [15:0] UF_MAX = 16'hFFFF;
   localparam logic [15:0] UF_ONE = 16'd1;

   // Saturating count of reads that fell due on an empty ring
   always_ff @(posedge i_dev_clk) begin
      if (i_dev_rst || w_accept)                      r_uf_cnt <= '0;
      else if (w_due && i_ring_empty && r_uf_cnt != UF_MAX) r_uf_cnt <= r_uf_cnt + UF_ONE;
   end

   assign o_underflow_cnt = r_uf_cnt;
`endif

   // Strobes decode registered state with the live ring_empty so a read is
   // suppressed in exactly the cycle the ring reports empty.
   assign o_rd_en_ring  = w_rd;
   assign o_frame_start = w_due && (r_slot == '0);
   assign o_busy        = (r_state != IDLE);
   assign o_underflow   = r_underflow;
   assign o_frame_cnt   = r_frame_cnt;
   assign o_tone_valid  = r_tone_valid;
   assign o_tone_idx    = r_tone_idx;
   assign o_tone_slot   = r_tone_slot;

endmodule
